// File: rtl/gcd_pkg.sv
// gcd_pkg: types and constants shared by the gcd core, its front-end driver
// (gcd_driver) and downstream consumers.
//   GCD_W            default operand/result width
//   gcd_word_t       one operand/result word
//   gcd_drv_state_t  gcd_driver sequencer states
//   is_core_phase()  true while the driver is talking to the core
package gcd_pkg;

   parameter int unsigned GCD_W = 16;

   typedef logic [GCD_W-1:0] gcd_word_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ_A,
      REL_A,
      REQ_B,
      REL_B,
      OUT
   } gcd_drv_state_t;

   // States in which the latency counter runs.
   function automatic logic is_core_phase(gcd_drv_state_t s);
      return (s inside {REQ_A, REL_A, REQ_B, REL_B});
   endfunction

endpackage

// File: rtl/gcd_driver_if.sv
// gcd_driver_if: signal bundle around gcd_driver.
//   Input port  : in_valid/in_ready/in_a/in_b      (operand pair, valid/ready)
//   Output port : out_valid/out_ready/out_c/out_lat (result + latency, valid/ready)
//   Core port   : gcd_req/gcd_ab/gcd_ack/gcd_c     (4-phase req/ack to the gcd core)
// Modports:
//   slave  - the gcd_driver itself
//   master - the environment around it (producer, consumer and gcd core)
interface gcd_driver_if
   import gcd_pkg::*;
#(
   parameter int unsigned W     = GCD_W,
   parameter int unsigned CNT_W = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_c;
   logic [CNT_W-1:0] out_lat;
   logic             gcd_req;
   logic [W-1:0]     gcd_ab;
   logic             gcd_ack;
   logic [W-1:0]     gcd_c;

   modport slave (
      input  in_valid, in_a, in_b, out_ready, gcd_ack, gcd_c,
      output in_ready, out_valid, out_c, out_lat, gcd_req, gcd_ab
   );

   modport master (
      output in_valid, in_a, in_b, out_ready, gcd_ack, gcd_c,
      input  in_ready, out_valid, out_c, out_lat, gcd_req, gcd_ab
   );

endinterface

// File: rtl/gcd_driver_sat_counter.sv
// gcd_driver_sat_counter: up-counter with synchronous clear that saturates at
// all-ones instead of wrapping.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset (count -> 0)
//   i_clr  synchronous clear, wins over i_en
//   i_en   count enable
//   o_cnt  current count
module gcd_driver_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/gcd_driver.sv
// gcd_driver: front-end sequencer for the gcd FSMD core. Accepts one (A, B)
// pair, sends A then B over the core's shared AB bus with a 4-phase req/ack
// handshake, captures C and offers it with the transaction latency.
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   io_bus  gcd_driver_if.slave (input pair, result, core handshake)
// Build option GCD_ZERO_GUARD_EN: a pair with a zero operand bypasses the core
// and completes with C = A | B and latency 0.
module gcd_driver
   import gcd_pkg::*;
#(
   parameter int unsigned W     = GCD_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic         clk,
   input  logic         reset,
   gcd_driver_if.slave  io_bus
);

   gcd_drv_state_t   r_state;
   gcd_drv_state_t   w_state_nxt;
   logic [W-1:0]     r_op_a;
   logic [W-1:0]     w_op_a_nxt;
   logic [W-1:0]     r_op_b;
   logic [W-1:0]     w_op_b_nxt;
   logic [W-1:0]     r_res;
   logic [W-1:0]     w_res_nxt;

   logic             w_lat_clr;
   logic             w_lat_en;
   logic [CNT_W-1:0] w_lat;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_gcd_req;
   logic [W-1:0]     w_gcd_ab;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_op_a  <= w_op_a_nxt;
         r_op_b  <= w_op_b_nxt;
         r_res   <= w_res_nxt;
      end
   end

   // Outputs depend on r_state and registers only; inputs feed next state only.
   always_comb begin
      w_state_nxt = r_state;
      w_op_a_nxt  = r_op_a;
      w_op_b_nxt  = r_op_b;
      w_res_nxt   = r_res;
      w_lat_clr   = 1'b0;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_gcd_req   = 1'b0;
      w_gcd_ab    = r_op_b;

      unique case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (io_bus.in_valid) begin
               w_op_a_nxt = io_bus.in_a;
               w_op_b_nxt = io_bus.in_b;
               w_lat_clr  = 1'b1;
`ifdef GCD_ZERO_GUARD_EN
               // gcd(x, 0) = x and gcd(0, 0) = 0; the core would never finish.
               if ((io_bus.in_a == '0) || (io_bus.in_b == '0)) begin
                  w_res_nxt   = io_bus.in_a | io_bus.in_b;
                  w_state_nxt = OUT;
               end else begin
                  w_state_nxt = REQ_A;
               end
`else
               w_state_nxt = REQ_A;
`endif
            end
         end
         REQ_A: begin
            w_gcd_req = 1'b1;
            w_gcd_ab  = r_op_a;
            if (io_bus.gcd_ack) begin
               w_state_nxt = REL_A;
            end
         end
         REL_A: begin
            w_gcd_ab = r_op_a;
            if (!io_bus.gcd_ack) begin
               w_state_nxt = REQ_B;
            end
         end
         REQ_B: begin
            w_gcd_req = 1'b1;
            w_gcd_ab  = r_op_b;
            // C is only meaningful while ack is high in the B phase.
            if (io_bus.gcd_ack) begin
               w_res_nxt   = io_bus.gcd_c;
               w_state_nxt = REL_B;
            end
         end
         REL_B: begin
            w_gcd_ab = r_op_b;
            if (!io_bus.gcd_ack) begin
               w_state_nxt = OUT;
            end
         end
         OUT: begin
            w_out_valid = 1'b1;
            if (io_bus.out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_lat_en = is_core_phase(r_state);

   gcd_driver_sat_counter #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_lat_clr),
      .i_en  (w_lat_en),
      .o_cnt (w_lat)
   );

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = w_out_valid;
   assign io_bus.out_c     = r_res;
   assign io_bus.out_lat   = w_lat;
   assign io_bus.gcd_req   = w_gcd_req;
   assign io_bus.gcd_ab    = w_gcd_ab;

endmodule

// File: tb/tb_gcd_driver.sv
// tb_gcd_driver: self-checking bench for gcd_driver. A behavioural gcd core
// answers the req/ack handshake with a configurable delay; results and
// latencies are compared against a Euclid model and cycle counts.
module tb_gcd_driver;

   localparam int unsigned W       = 16;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned LAT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic reset;

   gcd_driver_if #(.W(W), .CNT_W(CNT_W)) bus ();

   gcd_driver #(
      .W     (W),
      .CNT_W (CNT_W)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
      int unsigned x = a;
      int unsigned y = b;
      int unsigned t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int unsigned model_c(input int unsigned a, input int unsigned b);
`ifdef GCD_ZERO_GUARD_EN
      if (a == 0 || b == 0) return a | b;
`endif
      return ref_gcd(a, b);
   endfunction

   // Behavioural gcd core
   int unsigned core_delay = 1;
   int unsigned core_cnt   = 0;
   int unsigned core_st    = 0;
   int unsigned req_rises  = 0;
   int unsigned ab_glitch  = 0;
   bit          core_phase = 1'b0;
   bit          req_prev   = 1'b0;
   logic [W-1:0] core_ab = '0;
   logic [W-1:0] core_a  = '0;
   logic [W-1:0] core_b  = '0;

   initial begin
      bus.gcd_ack = 1'b0;
      bus.gcd_c   = W'($urandom);
      forever begin
         @(negedge clk);
         if (!reset) begin
            bus.gcd_ack = 1'b0;
            core_st     = 0;
            core_phase  = 1'b0;
            req_prev    = 1'b0;
         end else begin
            if (bus.gcd_req && !req_prev) req_rises++;
            req_prev = bus.gcd_req;
            case (core_st)
               0: if (bus.gcd_req) begin
                  core_cnt = core_delay;
                  core_ab  = bus.gcd_ab;
                  core_st  = 1;
               end
               1: begin
                  if (bus.gcd_ab !== core_ab) ab_glitch++;
                  if (core_cnt == 0) begin
                     if (!core_phase) begin
                        core_a = bus.gcd_ab;
                     end else begin
                        core_b    = bus.gcd_ab;
                        bus.gcd_c = W'(ref_gcd(core_a, core_b));
                     end
                     bus.gcd_ack = 1'b1;
                     core_st     = 2;
                  end else begin
                     core_cnt--;
                  end
               end
               default: if (!bus.gcd_req) begin
                  bus.gcd_ack = 1'b0;
                  bus.gcd_c   = W'($urandom);
                  core_phase  = ~core_phase;
                  core_st     = 0;
               end
            endcase
         end
      end
   end

   // Transaction tasks
   int unsigned cur_a, cur_b, acc_cyc, rise_base;

   task automatic send(input int unsigned a, input int unsigned b, input bit keep);
      bit ok = 1'b0;
      cur_a      = a;
      cur_b      = b;
      rise_base  = req_rises;
      bus.in_a   = W'(a);
      bus.in_b   = W'(b);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.in_ready) begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            ok      = 1'b1;
         end
         @(negedge clk);
      end
      chk("accept_timeout", 32'(ok), 1);
      if (!keep) begin
         bus.in_valid = 1'b0;
         bus.in_a     = W'($urandom);
         bus.in_b     = W'($urandom);
      end
   endtask

   task automatic recv(input int unsigned hold, input bit zero_path);
      bit ok = 1'b0;
      int unsigned exp_c;
      int unsigned exp_lat;
      exp_c = model_c(cur_a, cur_b);
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (bus.out_valid) ok = 1'b1;
         else @(negedge clk);
      end
      chk("out_timeout", 32'(ok), 1);
      exp_lat = zero_path ? 0 : (((cyc - acc_cyc) > LAT_MAX) ? LAT_MAX : (cyc - acc_cyc));
      chk("out_c", 32'(bus.out_c), exp_c);
      chk("out_lat", 32'(bus.out_lat), exp_lat);
      chk("in_ready_busy", 32'(bus.in_ready), 0);
      chk("req_in_out", 32'(bus.gcd_req), 0);
      if (zero_path) begin
         chk("req_rises", req_rises - rise_base, 0);
      end else begin
         chk("req_rises", req_rises - rise_base, 2);
         chk("ab_a", 32'(core_a), cur_a);
         chk("ab_b", 32'(core_b), cur_b);
      end
      for (int i = 0; i < int'(hold); i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(bus.out_valid), 1);
         chk("hold_c", 32'(bus.out_c), exp_c);
         chk("hold_lat", 32'(bus.out_lat), exp_lat);
         chk("hold_in_ready", 32'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_valid", 32'(bus.out_valid), 0);
      chk("post_in_ready", 32'(bus.in_ready), 1);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int unsigned g, a, b;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_gcd_req", 32'(bus.gcd_req), 0);
      chk("rst_gcd_ab", 32'(bus.gcd_ab), 0);
      chk("rst_out_c", 32'(bus.out_c), 0);
      chk("rst_out_lat", 32'(bus.out_lat), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Directed pairs; the first one also holds the result for 10 cycles.
      core_delay = 1;
      send(48, 18, 1'b0);    recv(10, 1'b0);
      send(100, 75, 1'b0);   recv(0, 1'b0);
      send(7, 7, 1'b0);      recv(1, 1'b0);
      send(1, 65535, 1'b0);  recv(0, 1'b0);

      // Slow core: latency saturates at the counter's maximum.
      core_delay = 150;
      send(65535, 65534, 1'b0);
      recv(2, 1'b0);
      core_delay = 0;

      // Back-to-back: the second pair waits in in_valid during OUT.
      send(12, 8, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_a     = W'(9);
      bus.in_b     = W'(6);
      recv(3, 1'b0);
      send(9, 6, 1'b0);
      recv(0, 1'b0);

      // Reset while the driver is in the B request phase.
      core_delay = 8;
      send(30, 45, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (core_phase && bus.gcd_req) found = 1'b1;
         else @(negedge clk);
      end
      chk("reach_req_b", 32'(found), 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_req", 32'(bus.gcd_req), 0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      core_delay = 2;
      @(negedge clk);
      send(20, 15, 1'b0);
      recv(0, 1'b0);

      // Randomised pairs sharing a random common factor.
      for (int k = 0; k < 10; k++) begin
         g = $urandom_range(1, 300);
         a = g * $urandom_range(1, 200);
         b = g * $urandom_range(1, 200);
         core_delay = $urandom_range(0, 4);
         send(a, b, 1'b0);
         recv($urandom_range(0, 3), 1'b0);
      end

`ifdef GCD_ZERO_GUARD_EN
      send(0, 25, 1'b0);  recv(2, 1'b1);
      send(0, 0, 1'b0);   recv(0, 1'b1);
      send(40, 0, 1'b0);  recv(1, 1'b1);
`endif

      chk("ab_stable", ab_glitch, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
